// File: rtl/t09_sound_event_arbiter.sv
// Sound-event front end: edge-detects per-channel event levels, queues them as
// pending requests and plays one fixed-length tone window at a time, channel 0 first.
module t09_sound_event_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int DURATION = 4,
  parameter int PREEMPT  = 1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              mute_i,
  output logic [NUM_CH-1:0] active_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [NUM_CH-1:0] pending_o
);

  localparam int CW = (DURATION > 1) ? $clog2(DURATION) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DURATION - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] s_q, s_d;
  logic [NUM_CH-1:0] p_q, p_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] active_q, active_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [NUM_CH-1:0] edges;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] higher_mask;

  always_comb begin
    s_d         = event_i;
    p_d         = s_q;
    edges       = s_q & ~p_q;
    req         = pend_q | edges;
    // Isolate the lowest set bit: that is the highest-priority requester.
    grant       = req & (~req + NUM_CH'(1));
    higher_mask = active_q - NUM_CH'(1);

    state_d  = state_q;
    pend_d   = req;
    active_d = active_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mute_i) begin
          pend_d = '0;
        end else if (|req) begin
          active_d = grant;
          pend_d   = req & ~grant;
          cnt_d    = CNT_MAX;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (mute_i) begin
          active_d = '0;
          pend_d   = '0;
          state_d  = IDLE;
        end else if (|(edges & active_q)) begin
          cnt_d  = CNT_MAX;
          pend_d = pend_q | (edges & ~active_q);
        end else if ((PREEMPT != 0) && (|(req & higher_mask))) begin
          // The aborted channel is simply dropped; it is never re-pended.
          active_d = grant;
          pend_d   = req & ~grant;
          cnt_d    = CNT_MAX;
        end else if (cnt_q == '0) begin
          done_d = 1'b1;
          if (|req) begin
            active_d = grant;
            pend_d   = req & ~grant;
            cnt_d    = CNT_MAX;
          end else begin
            active_d = '0;
            state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        active_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      p_q      <= '0;
      pend_q   <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      p_q      <= p_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign active_o  = active_q;
  assign busy_o    = |active_q;
  assign done_o    = done_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_t09_sound_event_arbiter.sv
// Directed bench for the sound-event arbiter: preempting, non-preempting and
// single-cycle-window instances share stimulus; expectations flow through a scoreboard queue.
module tb_t09_sound_event_arbiter;

  logic       clk;
  logic       nRst;
  logic [2:0] event_i;
  logic       mute_i;

  logic [2:0] act_a, pend_a, act_b, pend_b, act_c, pend_c;
  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string      tag;
    logic [2:0] a, p, a2, p2, a3;
    logic       d, d2, d3, chk3;
  } exp_t;

  exp_t sb[$];

  t09_sound_event_arbiter #(.NUM_CH(3), .DURATION(4), .PREEMPT(1)) dut (
    .clk(clk), .nRst(nRst), .event_i(event_i), .mute_i(mute_i),
    .active_o(act_a), .busy_o(busy_a), .done_o(done_a), .pending_o(pend_a));

  t09_sound_event_arbiter #(.NUM_CH(3), .DURATION(4), .PREEMPT(0)) dut_np (
    .clk(clk), .nRst(nRst), .event_i(event_i), .mute_i(mute_i),
    .active_o(act_b), .busy_o(busy_b), .done_o(done_b), .pending_o(pend_b));

  t09_sound_event_arbiter #(.NUM_CH(3), .DURATION(1), .PREEMPT(1)) dut_d1 (
    .clk(clk), .nRst(nRst), .event_i(event_i), .mute_i(mute_i),
    .active_o(act_c), .busy_o(busy_c), .done_o(done_c), .pending_o(pend_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    checkOne({e.tag, ".active"},    act_a,          e.a);
    checkOne({e.tag, ".busy"},      {2'b0, busy_a}, {2'b0, |e.a});
    checkOne({e.tag, ".done"},      {2'b0, done_a}, {2'b0, e.d});
    checkOne({e.tag, ".pend"},      pend_a,         e.p);
    checkOne({e.tag, ".np_active"}, act_b,          e.a2);
    checkOne({e.tag, ".np_busy"},   {2'b0, busy_b}, {2'b0, |e.a2});
    checkOne({e.tag, ".np_done"},   {2'b0, done_b}, {2'b0, e.d2});
    checkOne({e.tag, ".np_pend"},   pend_b,         e.p2);
    if (e.chk3) begin
      checkOne({e.tag, ".d1_active"}, act_c,          e.a3);
      checkOne({e.tag, ".d1_done"},   {2'b0, done_c}, {2'b0, e.d3});
    end
  endtask

  // Drive one cycle of inputs, record what must appear after the next edge, then check it.
  task automatic applyStimulus(input string tag, input logic [2:0] ev, input logic mute,
                               input logic [2:0] a, input logic d, input logic [2:0] p,
                               input logic [2:0] a2, input logic d2, input logic [2:0] p2,
                               input logic chk3, input logic [2:0] a3, input logic d3);
    exp_t e;
    e.tag = tag; e.a = a; e.d = d; e.p = p; e.a2 = a2; e.d2 = d2; e.p2 = p2;
    e.chk3 = chk3; e.a3 = a3; e.d3 = d3;
    event_i = ev;
    mute_i  = mute;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic same(input string tag, input logic [2:0] ev, input logic mute,
                      input logic [2:0] a, input logic d, input logic [2:0] p);
    applyStimulus(tag, ev, mute, a, d, p, a, d, p, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    nRst    = 1'b0;
    event_i = 3'b111;
    mute_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOne("rst.active", act_a,          3'b000);
    checkOne("rst.busy",   {2'b0, busy_a}, 3'b000);
    checkOne("rst.done",   {2'b0, done_a}, 3'b000);
    checkOne("rst.pend",   pend_a,         3'b000);
    checkOne("rst.d1",     act_c,          3'b000);
    nRst = 1'b1;

    // Levels held high across reset release: one edge per channel, three back-to-back windows.
    applyStimulus("rel0", 3'b111, 0, 3'b000, 0, 3'b000, 3'b000, 0, 3'b000, 1, 3'b000, 0);
    applyStimulus("rel1", 3'b111, 0, 3'b001, 0, 3'b110, 3'b001, 0, 3'b110, 1, 3'b001, 0);
    applyStimulus("rel2", 3'b111, 0, 3'b001, 0, 3'b110, 3'b001, 0, 3'b110, 1, 3'b010, 1);
    applyStimulus("rel3", 3'b111, 0, 3'b001, 0, 3'b110, 3'b001, 0, 3'b110, 1, 3'b100, 1);
    applyStimulus("rel4", 3'b111, 0, 3'b001, 0, 3'b110, 3'b001, 0, 3'b110, 1, 3'b000, 1);
    applyStimulus("rel5", 3'b111, 0, 3'b010, 1, 3'b100, 3'b010, 1, 3'b100, 1, 3'b000, 0);
    for (int i = 0; i < 3; i++) same("rel6", 3'b111, 0, 3'b010, 0, 3'b100);
    same("rel9", 3'b111, 0, 3'b100, 1, 3'b000);
    for (int i = 0; i < 3; i++) same("rel10", 3'b111, 0, 3'b100, 0, 3'b000);
    same("rel13", 3'b111, 0, 3'b000, 1, 3'b000);
    same("rel14", 3'b111, 0, 3'b000, 0, 3'b000);
    same("rel15", 3'b000, 0, 3'b000, 0, 3'b000);
    same("rel16", 3'b000, 0, 3'b000, 0, 3'b000);

    // Single pulse on ch1 from idle.
    same("ch1.0", 3'b010, 0, 3'b000, 0, 3'b000);
    for (int i = 0; i < 4; i++) same("ch1.win", 3'b000, 0, 3'b010, 0, 3'b000);
    same("ch1.done", 3'b000, 0, 3'b000, 1, 3'b000);
    same("ch1.idle", 3'b000, 0, 3'b000, 0, 3'b000);

    // ch2 playing, ch0 arrives: preempting instance switches, the other queues it.
    same("pre.A", 3'b100, 0, 3'b000, 0, 3'b000);
    same("pre.B", 3'b000, 0, 3'b100, 0, 3'b000);
    same("pre.C", 3'b001, 0, 3'b100, 0, 3'b000);
    applyStimulus("pre.D", 3'b000, 0, 3'b001, 0, 3'b000, 3'b100, 0, 3'b001, 0, 3'b000, 0);
    applyStimulus("pre.E", 3'b000, 0, 3'b001, 0, 3'b000, 3'b100, 0, 3'b001, 0, 3'b000, 0);
    applyStimulus("pre.F", 3'b000, 0, 3'b001, 0, 3'b000, 3'b001, 1, 3'b000, 0, 3'b000, 0);
    applyStimulus("pre.G", 3'b000, 0, 3'b001, 0, 3'b000, 3'b001, 0, 3'b000, 0, 3'b000, 0);
    applyStimulus("pre.H", 3'b000, 0, 3'b000, 1, 3'b000, 3'b001, 0, 3'b000, 0, 3'b000, 0);
    applyStimulus("pre.I", 3'b000, 0, 3'b000, 0, 3'b000, 3'b001, 0, 3'b000, 0, 3'b000, 0);
    applyStimulus("pre.J", 3'b000, 0, 3'b000, 0, 3'b000, 3'b000, 1, 3'b000, 0, 3'b000, 0);
    same("pre.K", 3'b000, 0, 3'b000, 0, 3'b000);

    // Retrigger ch1 while its counter is at 1: window stretches to seven cycles.
    same("rtg.A", 3'b010, 0, 3'b000, 0, 3'b000);
    same("rtg.B", 3'b000, 0, 3'b010, 0, 3'b000);
    same("rtg.C", 3'b000, 0, 3'b010, 0, 3'b000);
    same("rtg.D", 3'b010, 0, 3'b010, 0, 3'b000);
    for (int i = 0; i < 4; i++) same("rtg.win", 3'b000, 0, 3'b010, 0, 3'b000);
    same("rtg.done", 3'b000, 0, 3'b000, 1, 3'b000);
    same("rtg.idle", 3'b000, 0, 3'b000, 0, 3'b000);

    // Mute mid-window with ch2 pending; ch0 held high through unmute stays silent.
    same("mut.A", 3'b110, 0, 3'b000, 0, 3'b000);
    same("mut.B", 3'b000, 0, 3'b010, 0, 3'b100);
    same("mut.C", 3'b000, 0, 3'b010, 0, 3'b100);
    same("mut.D", 3'b001, 1, 3'b000, 0, 3'b000);
    same("mut.E", 3'b001, 1, 3'b000, 0, 3'b000);
    for (int i = 0; i < 4; i++) same("mut.held", 3'b001, 0, 3'b000, 0, 3'b000);
    same("mut.end", 3'b000, 0, 3'b000, 0, 3'b000);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
